// File: rtl/vga_pkg.sv
// Shared raster constants for the 1024x768@60 display path.
// Drawing stages import this package as well as the timing generator.
package vga_pkg;

   localparam int   CNT_W       = 16;
   localparam int   CELL_W      = 6;

   localparam int   H_ACTIVE    = 1024;
   localparam int   H_FP        = 24;
   localparam int   H_SYNC      = 136;
   localparam int   H_BP        = 160;
   localparam int   H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int   V_ACTIVE    = 768;
   localparam int   V_FP        = 3;
   localparam int   V_SYNC      = 6;
   localparam int   V_BP        = 29;
   localparam int   V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic SYNC_ACTIVE = 1'b0;

   localparam int   CELL_SHIFT  = 5;
   localparam int   GRID_COLS   = H_ACTIVE >> CELL_SHIFT;
   localparam int   GRID_ROWS   = V_ACTIVE >> CELL_SHIFT;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/blank decodes.
// Decodes are taken from the next count so they register in step with it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int   ACTIVE      = H_ACTIVE,
   parameter int   FP          = H_FP,
   parameter int   SYNC        = H_SYNC,
   parameter int   BP          = H_BP,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_next,
   output logic             o_wrap,
   output logic             o_sync,
   output logic             o_blank
);

   localparam int               TOTAL   = ACTIVE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);
   localparam logic [CNT_W-1:0] ACT     = CNT_W'(ACTIVE);

   logic [CNT_W-1:0] r_count;
   logic             r_sync;
   logic             r_blank;

   logic [CNT_W-1:0] w_next;
   logic             w_wrap;
   logic             w_sync_nxt;
   logic             w_blank_nxt;

   // Next count (hold when disabled, wrap after TOTAL-1) and its decodes
   always_comb begin
      w_wrap = i_en && (r_count == LAST);
      if (!i_en)
         w_next = r_count;
      else if (w_wrap)
         w_next = '0;
      else
         w_next = r_count + CNT_W'(1);
      w_sync_nxt  = ((w_next >= SYNC_LO) && (w_next <= SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      w_blank_nxt = (w_next >= ACT);
   end

   // Register count and decodes together so they never skew
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_sync  <= ~SYNC_ACTIVE;
         r_blank <= 1'b0;
      end else begin
         r_count <= w_next;
         r_sync  <= w_sync_nxt;
         r_blank <= w_blank_nxt;
      end
   end

   assign o_count = r_count;
   assign o_next  = w_next;
   assign o_wrap  = w_wrap;
   assign o_sync  = r_sync;
   assign o_blank = r_blank;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source. Every output is registered from
// the same next-pixel values, so all of them describe one pixel per cycle.
module vga_timing_gen #(
   parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int   H_FP        = vga_pkg::H_FP,
   parameter int   H_SYNC      = vga_pkg::H_SYNC,
   parameter int   H_BP        = vga_pkg::H_BP,
   parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int   V_FP        = vga_pkg::V_FP,
   parameter int   V_SYNC      = vga_pkg::V_SYNC,
   parameter int   V_BP        = vga_pkg::V_BP,
   parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
   parameter int   CELL_SHIFT  = vga_pkg::CELL_SHIFT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [vga_pkg::CNT_W-1:0]  hcount_out,
   output logic [vga_pkg::CNT_W-1:0]  vcount_out,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic                       hblnk_out,
   output logic                       vblnk_out,
   output logic [vga_pkg::CELL_W-1:0] cell_x_out,
   output logic [vga_pkg::CELL_W-1:0] cell_y_out,
   output logic                       frame_tick_out
);

   import vga_pkg::*;

   localparam logic [CNT_W-1:0] V_TICK = CNT_W'(V_ACTIVE);

   logic [CNT_W-1:0]  w_h_next;
   logic [CNT_W-1:0]  w_v_next;
   logic              w_h_wrap;
   logic              w_v_wrap;
   logic              w_tick_nxt;

   logic [CELL_W-1:0] r_cell_x;
   logic [CELL_W-1:0] r_cell_y;
   logic              r_frame_tick;

   vga_axis_counter #(
      .ACTIVE      (H_ACTIVE),
      .FP          (H_FP),
      .SYNC        (H_SYNC),
      .BP          (H_BP),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_h_axis (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (1'b1),
      .o_count (hcount_out),
      .o_next  (w_h_next),
      .o_wrap  (w_h_wrap),
      .o_sync  (hsync_out),
      .o_blank (hblnk_out)
   );

   // Vertical axis advances once per line, on the horizontal wrap
   vga_axis_counter #(
      .ACTIVE      (V_ACTIVE),
      .FP          (V_FP),
      .SYNC        (V_SYNC),
      .BP          (V_BP),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_v_axis (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (w_h_wrap),
      .o_count (vcount_out),
      .o_next  (w_v_next),
      .o_wrap  (w_v_wrap),
      .o_sync  (vsync_out),
      .o_blank (vblnk_out)
   );

   // Tick on the first pixel of vertical blank; excluding the frame wrap
   // keeps it from firing at (0,0) in a degenerate V_ACTIVE=0 build
   assign w_tick_nxt = (w_h_next == '0) && (w_v_next == V_TICK) && !w_v_wrap;

   // Cell indices and frame tick registered alongside the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cell_x     <= '0;
         r_cell_y     <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_cell_x     <= CELL_W'(w_h_next >> CELL_SHIFT);
         r_cell_y     <= CELL_W'(w_v_next >> CELL_SHIFT);
         r_frame_tick <= w_tick_nxt;
      end
   end

   assign cell_x_out     = r_cell_x;
   assign cell_y_out     = r_cell_y;
   assign frame_tick_out = r_frame_tick;

endmodule
